// File: rtl/inv_key_stream.sv
// Reverse AES-128 key schedule: streams round keys 10 down to 0 over a valid/ready port.
// Optional build macro INV_KEY_PIPE_EN registers the SubWord result and adds a STEP state.
module inv_key_stream (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic [1:0]   fsm_state
);

  // Handshake: a round key moves when out_valid && out_ready at a rising edge;
  // out_key/out_round are held while out_valid is high and out_ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] b;
    case (r)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    rcon = {b, 24'h000000};
  endfunction

  state_t       state;
  state_t       state_n;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         accept;
  logic         xfer;
  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  sub_w;
  logic [127:0] prev_key;

  assign accept = (state == IDLE) && start;
  assign xfer   = (state == EMIT) && out_ready;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

`ifdef INV_KEY_PIPE_EN
  // SubWord is captured on the transfer edge and consumed during STEP.
  logic [31:0] sub_q;
  assign sub_w = sub_q;
`else
  assign sub_w = sub_word({p3[23:0], p3[31:24]});
`endif

  assign p0       = k0 ^ sub_w ^ rcon(round_q);
  assign prev_key = {p0, p1, p2, p3};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (round_q == 4'd0) state_n = IDLE;
`ifdef INV_KEY_PIPE_EN
          else                 state_n = STEP;
`else
          else                 state_n = EMIT;
`endif
        end
      end
      STEP:    state_n = EMIT;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == EMIT);
    out_last  = (state == EMIT) && (round_q == 4'd0);
    out_key   = key_q;
    out_round = round_q;
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      round_q <= '0;
    end else if (accept) begin
      key_q   <= key_in;
      round_q <= 4'd10;
`ifdef INV_KEY_PIPE_EN
    end else if (state == STEP) begin
      key_q   <= prev_key;
      round_q <= round_q - 4'd1;
    end
`else
    end else if (xfer && (round_q != 4'd0)) begin
      key_q   <= prev_key;
      round_q <= round_q - 4'd1;
    end
`endif
  end

`ifdef INV_KEY_PIPE_EN
  always_ff @(posedge clk) begin
    if (rst)                          sub_q <= '0;
    else if (xfer && round_q != 4'd0) sub_q <= sub_word({p3[23:0], p3[31:24]});
  end
`endif

endmodule
